// File: rtl/bitslice_mul_seq_if.sv
// rtl/bitslice_mul_seq_if.sv - operand/result handshake bundle for bitslice_mul_seq
// Optional acc_clr_i exists only when BSLICE_MUL_MAC_EN is defined.
interface bitslice_mul_seq_if #(
  parameter int LANES = 16,
  parameter int OPW   = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [OPW*LANES-1:0]    a_i;
  logic [OPW*LANES-1:0]    b_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*OPW*LANES-1:0]  y_o;
  logic                    busy_o;
`ifdef BSLICE_MUL_MAC_EN
  logic                    acc_clr_i;

  modport master (output in_valid, a_i, b_i, out_ready, acc_clr_i,
                  input  in_ready, out_valid, y_o, busy_o);
  modport slave  (input  in_valid, a_i, b_i, out_ready, acc_clr_i,
                  output in_ready, out_valid, y_o, busy_o);
`else
  modport master (output in_valid, a_i, b_i, out_ready,
                  input  in_ready, out_valid, y_o, busy_o);
  modport slave  (input  in_valid, a_i, b_i, out_ready,
                  output in_ready, out_valid, y_o, busy_o);
`endif
endinterface

// File: rtl/bitslice_mul_seq.sv
// rtl/bitslice_mul_seq.sv - sequential bit-sliced multiplier, one B plane per cycle
// Optional multiply-accumulate mode: BSLICE_MUL_MAC_EN.
module bitslice_mul_seq #(
  parameter int LANES = 16,
  parameter int OPW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  bitslice_mul_seq_if.slave bus
);
  localparam int AW = OPW * LANES;
  localparam int YW = 2 * OPW * LANES;
  localparam int KW = (OPW > 1) ? $clog2(OPW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [AW-1:0]  a_q;
  logic [AW-1:0]  b_q;
  logic [YW-1:0]  acc_q;
  logic [YW-1:0]  acc_sum;
  logic [KW-1:0]  k_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic           clr;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy_o    = busy_q;
  assign bus.y_o       = acc_q;

`ifdef BSLICE_MUL_MAC_EN
  assign clr = bus.acc_clr_i;
`else
  assign clr = 1'b1;
`endif

  // Partial product for plane k, placed at planes k..k+OPW-1, rippled plane by plane.
  always_comb begin
    logic [LANES-1:0] bk;
    logic [LANES-1:0] x;
    logic [LANES-1:0] y;
    logic [LANES-1:0] c;
    logic [AW-1:0]    pp;
    logic [YW-1:0]    addend;
    bk      = b_q[int'(k_q)*LANES +: LANES];
    pp      = '0;
    x       = '0;
    y       = '0;
    c       = '0;
    acc_sum = '0;
    for (int i = 0; i < OPW; i++)
      pp[i*LANES +: LANES] = a_q[i*LANES +: LANES] & bk;
    addend = {{AW{1'b0}}, pp} << (int'(k_q) * LANES);
    for (int j = 0; j < 2*OPW; j++) begin
      x = acc_q[j*LANES +: LANES];
      y = addend[j*LANES +: LANES];
      acc_sum[j*LANES +: LANES] = x ^ y ^ c;
      c = (x & y) | (c & (x ^ y));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a_i;
            b_q        <= bus.b_i;
            if (clr)
              acc_q    <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_sum;
          if (k_q == KW'(OPW - 1)) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitslice_mul_seq.sv
// tb/tb_bitslice_mul_seq.sv - randomized self-checking bench for bitslice_mul_seq
module tb_bitslice_mul_seq;
  localparam int LANES = 16;
  localparam int OPW   = 2;
  localparam int AW    = OPW * LANES;
  localparam int YW    = 2 * OPW * LANES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [YW-1:0] exp_prev = '0;

  bitslice_mul_seq_if #(.LANES(LANES), .OPW(OPW)) bus ();

  bitslice_mul_seq #(.LANES(LANES), .OPW(OPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-lane integer arithmetic: unpack planes, multiply(-accumulate), repack.
  function automatic logic [YW-1:0] model(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                          input logic [YW-1:0] prev, input logic clr);
    logic [YW-1:0] y;
    y = '0;
    for (int l = 0; l < LANES; l++) begin
      int av, bv, pv, r;
      av = 0; bv = 0; pv = 0;
      for (int k = 0; k < OPW; k++) begin
        av += int'(a[k*LANES + l]) << k;
        bv += int'(b[k*LANES + l]) << k;
      end
      for (int k = 0; k < 2*OPW; k++)
        pv += int'(prev[k*LANES + l]) << k;
      r = ((clr ? 0 : pv) + av * bv) % (1 << (2*OPW));
      for (int k = 0; k < 2*OPW; k++)
        y[k*LANES + l] = ((r >> k) & 1) != 0;
    end
    return y;
  endfunction

  task automatic set_clr(input logic clr);
`ifdef BSLICE_MUL_MAC_EN
    bus.acc_clr_i = clr;
`else
    if (clr) bus.out_ready = bus.out_ready;
`endif
  endtask

  task automatic do_op(input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic clr, input int stall, output logic [YW-1:0] got);
    logic [YW-1:0] exp;
    int cnt;
`ifdef BSLICE_MUL_MAC_EN
    exp = model(a, b, exp_prev, clr);
`else
    exp = model(a, b, exp_prev, 1'b1);
`endif
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a_i = a;
    bus.b_i = b;
    set_clr(clr);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_run", bus.busy_o, 1);
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      bus.a_i = $urandom;
      bus.b_i = $urandom;
      @(posedge clk); #1;
      cnt++;
    end
    check("latency", cnt, OPW);
    check("y", bus.y_o, exp);
    check("in_ready_done", bus.in_ready, 0);
    got = bus.y_o;
    exp_prev = exp;
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      bus.a_i = $urandom;
      @(posedge clk); #1;
      check("hold_y", bus.y_o, exp);
      check("hold_state", {bus.out_valid, bus.in_ready, bus.busy_o}, 3'b100);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release", {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    logic [YW-1:0] y;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    set_clr(1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {bus.in_ready, bus.out_valid, bus.busy_o}, 3'b100);
    check("reset_y", bus.y_o, 0);
    rst = 1'b0;

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, y);
    check("all_3x3", y, 64'hFFFF_0000_0000_FFFF);
    do_op(32'h0001_0002, 32'h0001_0003, 1'b1, 0, y);
    check("mixed", y, 64'h0000_0001_0001_0002);
    do_op(32'hA5A5_3C3C, 32'h0F0F_FFFF, 1'b1, 5, y);

    // Asynchronous reset after the first add step.
    bus.in_valid = 1'b1;
    bus.a_i = 32'hFFFF_FFFF;
    bus.b_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_async", {bus.in_ready, bus.out_valid, bus.busy_o}, 3'b100);
    check("rst_y", bus.y_o, 0);
    #1;
    rst = 1'b0;
    exp_prev = '0;
    @(posedge clk); #1;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, y);
    check("after_rst_3x3", y, 64'hFFFF_0000_0000_FFFF);

`ifdef BSLICE_MUL_MAC_EN
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, y);
    do_op(32'hFFFF_0000, 32'hFFFF_0000, 1'b0, 0, y);
    check("mac_13", y, 64'hFFFF_FFFF_0000_FFFF);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, y);
    check("mac_6", y, 64'h0000_FFFF_FFFF_0000);
`endif

    for (int n = 0; n < 40; n++)
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), y);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
